// File: rtl/hpram_arbiter_pkg.sv
// Shared types for the HyperRAM arbiter: FSM state encoding, grant codes
// and default bus widths.
package hpram_arbiter_pkg;

  localparam int ADRS_W_DEF = 22;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_ACK        = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PPU  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_LDR  = 2'd3
  } grant_t;

endpackage

// File: rtl/hpram_prio_enc.sv
// Fixed-priority encoder: PPU over CPU over loader, producing a grant code.
module hpram_prio_enc
  import hpram_arbiter_pkg::*;
(
  input  logic   ppu_req,
  input  logic   cpu_req,
  input  logic   ldr_req,
  output grant_t code
);

  always_comb begin
    code = GNT_NONE;
    if (ppu_req)      code = GNT_PPU;
    else if (cpu_req) code = GNT_CPU;
    else if (ldr_req) code = GNT_LDR;
  end

endmodule

// File: rtl/hpram_arbiter.sv
// Shares one HyperRAM controller between PPU, CPU (readers) and the JTAG
// loader (writer); one transfer at a time, never pre-empted.
module hpram_arbiter
  import hpram_arbiter_pkg::*;
#(
  parameter int ADRS_W    = ADRS_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int START_TMO = 4
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              ppu_req,
  input  logic              cpu_req,
  input  logic              ldr_req,
  input  logic [ADRS_W-1:0] ppu_adrs,
  input  logic [ADRS_W-1:0] cpu_adrs,
  input  logic [ADRS_W-1:0] ldr_adrs,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ppu_ack,
  output logic              cpu_ack,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              hpram_read,
  output logic              hpram_write,
  output logic [ADRS_W-1:0] hpram_adrs,
  output logic [DATA_W-1:0] hpram_din,
  input  logic [DATA_W-1:0] hpram_dout,
  input  logic              hpram_busy,
  output logic [1:0]        grant
);

  localparam int CNT_W = (START_TMO > 1) ? $clog2(START_TMO) : 1;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d, win;
  logic [2:0]        ack_q, ack_d;
  logic              read_q, read_d, write_q, write_d;
  logic [ADRS_W-1:0] adrs_q, adrs_d;
  logic [DATA_W-1:0] din_q, din_d, rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  hpram_prio_enc u_prio (
    .ppu_req (ppu_req),
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .code    (win)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    read_d  = 1'b0;
    write_d = 1'b0;
    adrs_d  = adrs_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win != GNT_NONE && !hpram_busy) begin
          state_d = S_ISSUE;
          grant_d = win;
          read_d  = (win != GNT_LDR);
          write_d = (win == GNT_LDR);
          case (win)
            GNT_PPU: adrs_d = ppu_adrs;
            GNT_CPU: adrs_d = cpu_adrs;
            GNT_LDR: begin
              adrs_d = ldr_adrs;
              din_d  = ldr_wdata;
            end
            default: adrs_d = adrs_q;
          endcase
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_START;
        cnt_d   = '0;
      end
      // Controller may never acknowledge the command; give up waiting after
      // START_TMO cycles so the requester is not hung.
      S_WAIT_START: begin
        if (hpram_busy || cnt_q == CNT_W'(START_TMO - 1)) state_d = S_WAIT_DONE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_WAIT_DONE: begin
        if (!hpram_busy) begin
          state_d = S_ACK;
          case (grant_q)
            GNT_PPU: ack_d = 3'b001;
            GNT_CPU: ack_d = 3'b010;
            GNT_LDR: ack_d = 3'b100;
            default: ack_d = 3'b000;
          endcase
          if (grant_q != GNT_LDR) rdata_d = hpram_dout;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q <= S_IDLE;
      grant_q <= GNT_NONE;
      ack_q   <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      adrs_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      read_q  <= read_d;
      write_q <= write_d;
      adrs_q  <= adrs_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ppu_ack     = ack_q[0];
  assign cpu_ack     = ack_q[1];
  assign ldr_ack     = ack_q[2];
  assign hpram_read  = read_q;
  assign hpram_write = write_q;
  assign hpram_adrs  = adrs_q;
  assign hpram_din   = din_q;
  assign rdata       = rdata_q;
  assign grant       = grant_q;

endmodule
